// File: rtl/note_stream_source.sv
// note_stream_source: records live key state as run-length (word, duration) entries and replays them as a timed stream
// Ports: clk/rst (async active-high); rec_start/play_start/stop control pulses;
//   key_notes/key_shift live keyboard word; read_en consumer accept;
//   data_out {notes,shift} stream word; output_ready word valid;
//   rec_busy/play_busy activity flags; length stored entry count.
module note_stream_source #(
   parameter int ADDR_W   = 8,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 1000000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              rec_start,
   input  logic              play_start,
   input  logic              stop,
   input  logic [7:0]        key_notes,
   input  logic [1:0]        key_shift,
   input  logic              read_en,
   output logic [9:0]        data_out,
   output logic              output_ready,
   output logic              rec_busy,
   output logic              play_busy,
   output logic [ADDR_W:0]   length
);
   localparam int CW = $clog2(TICK_DIV);
   localparam int EW = 10 + DUR_W;
   localparam logic [ADDR_W:0]  DEPTH = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [DUR_W-1:0] DMAX  = '1;
   localparam logic [CW-1:0]    TLAST = CW'(TICK_DIV-1);
   typedef enum logic [2:0] {IDLE, REC, FLUSH, FETCH, HOLD} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, length_q, length_d;
   logic [9:0]        cur_q, cur_d, data_out_q, data_out_d;
   logic [DUR_W-1:0]  dur_q, dur_d, remain_q, remain_d;
   logic              output_ready_q, rec_busy_q, play_busy_q;
   logic [EW-1:0]     mem [2**ADDR_W];
   logic [EW-1:0]     rd_word;
   logic [9:0]        key;
   logic              we, adv, tick;
   assign key     = {key_notes, key_shift};
   // the stream pauses while the consumer is not reading
   assign adv     = state_q != HOLD || read_en;
   assign tick    = adv && cnt_q == TLAST;
   assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      length_d = length_q;
      cur_d    = cur_q;
      dur_d    = dur_q;
      remain_d = remain_q;
      we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!stop && rec_start) begin
               state_d  = REC;
               wr_ptr_d = '0;
               length_d = '0;
               cur_d    = key;
               dur_d    = '0;
            end else if (!stop && play_start && length_q != '0) begin
               state_d  = FETCH;
               rd_ptr_d = '0;
            end
         end
         REC: begin
            if (tick) begin
               if (key == cur_q && dur_q != DMAX) dur_d = dur_q + 1'b1;
               else begin
                  // a run only exists once it has lasted at least one tick
                  we       = dur_q != '0;
                  wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, we};
                  cur_d    = key;
                  dur_d    = DUR_W'(1);
               end
            end
            if (wr_ptr_d == DEPTH) begin
               state_d  = IDLE;
               length_d = DEPTH;
            end else if (stop) state_d = FLUSH;
         end
         FLUSH: begin
            we       = dur_q != '0 && wr_ptr_q != DEPTH;
            wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, we};
            length_d = wr_ptr_d;
            state_d  = IDLE;
         end
         FETCH: begin
            remain_d = rd_word[DUR_W-1:0];
            state_d  = HOLD;
         end
         HOLD: begin
            if (stop) state_d = IDLE;
            else if (tick) begin
               remain_d = remain_q - 1'b1;
               if (remain_q == DUR_W'(1)) begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  state_d  = rd_ptr_d == length_q ? IDLE : FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      cnt_d      = state_d != state_q || tick ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
      // data_out doubles as the registered memory read; it holds through FETCH
      data_out_d = state_d == IDLE ? 10'd0 : state_q == FETCH ? rd_word[EW-1:DUR_W] : data_out_q;
   end
   always_ff @(posedge clk)
      if (we) mem[wr_ptr_q[ADDR_W-1:0]] <= {cur_q, dur_q};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         length_q       <= '0;
         cur_q          <= '0;
         dur_q          <= '0;
         remain_q       <= '0;
         data_out_q     <= '0;
         output_ready_q <= 1'b0;
         rec_busy_q     <= 1'b0;
         play_busy_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         length_q       <= length_d;
         cur_q          <= cur_d;
         dur_q          <= dur_d;
         remain_q       <= remain_d;
         data_out_q     <= data_out_d;
         output_ready_q <= state_d == HOLD;
         rec_busy_q     <= state_d == REC || state_d == FLUSH;
         play_busy_q    <= state_d == FETCH || state_d == HOLD;
      end
   end
   assign data_out     = data_out_q;
   assign output_ready = output_ready_q;
   assign rec_busy     = rec_busy_q;
   assign play_busy    = play_busy_q;
   assign length       = length_q;
endmodule

// File: tb/tb_note_stream_source.sv
// tb_note_stream_source: directed self-checking bench for note_stream_source
module tb_note_stream_source;
   logic       clk = 1'b0, rst = 1'b1;
   logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, read_en = 1'b1;
   logic [9:0] key = '0;
   logic [9:0] data_out;
   logic       output_ready, rec_busy, play_busy;
   logic [3:0] length;
   int         errors = 0, checks = 0;
   note_stream_source #(.ADDR_W(3), .DUR_W(4), .TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start), .stop(stop),
      .key_notes(key[9:2]), .key_shift(key[1:0]), .read_en(read_en),
      .data_out(data_out), .output_ready(output_ready), .rec_busy(rec_busy),
      .play_busy(play_busy), .length(length)
   );
   always #5 clk = ~clk;
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic pulse(input int which);
      if (which == 0) rec_start = 1'b1;
      else if (which == 1) play_start = 1'b1;
      else stop = 1'b1;
      step(1);
      rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
   endtask
   initial begin
      step(3);
      chk("rst_ready", int'(output_ready), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_len", int'(length), 0);
      rst = 1'b0;
      // play with empty buffer is ignored
      pulse(1);
      chk("empty_play_busy", int'(play_busy), 0);
      chk("empty_play_ready", int'(output_ready), 0);
      chk("empty_play_len", int'(length), 0);
      // stop outranks rec_start
      rec_start = 1'b1; stop = 1'b1;
      step(1);
      rec_start = 1'b0; stop = 1'b0;
      chk("stop_prio", int'(rec_busy), 0);
      // record 0x044 x3 ticks, 0x108 x2 ticks
      key = 10'h044;
      pulse(0);
      chk("rec_busy", int'(rec_busy), 1);
      step(12);
      key = 10'h108;
      step(8);
      pulse(2);
      chk("flush_busy", int'(rec_busy), 1);
      step(1);
      chk("rec_done_busy", int'(rec_busy), 0);
      chk("rec_len", int'(length), 2);
      // playback 12 + FETCH + 8
      pulse(1);
      chk("fetch0_ready", int'(output_ready), 0);
      chk("fetch0_busy", int'(play_busy), 1);
      step(1);
      chk("hold0_first", int'(data_out), 'h044);
      step(11);
      chk("hold0_last_rdy", int'(output_ready), 1);
      chk("hold0_last", int'(data_out), 'h044);
      step(1);
      chk("fetch1_ready", int'(output_ready), 0);
      chk("fetch1_data", int'(data_out), 'h044);
      step(1);
      chk("hold1_first", int'(data_out), 'h108);
      step(7);
      chk("hold1_last_rdy", int'(output_ready), 1);
      step(1);
      chk("play_end_rdy", int'(output_ready), 0);
      chk("play_end_data", int'(data_out), 0);
      chk("play_end_busy", int'(play_busy), 0);
      chk("play_keeps_len", int'(length), 2);
      // read_en pause stretches the first word by 10 cycles
      pulse(1);
      step(3);
      read_en = 1'b0;
      step(10);
      chk("pause_rdy", int'(output_ready), 1);
      chk("pause_data", int'(data_out), 'h044);
      read_en = 1'b1;
      step(9);
      chk("pause_hold_last", int'(output_ready), 1);
      step(1);
      chk("pause_fetch", int'(output_ready), 0);
      step(1);
      chk("pause_word2", int'(data_out), 'h108);
      step(9);
      chk("pause_end", int'(output_ready), 0);
      // constant word for 20 ticks splits into 15 + 5
      key = 10'h081;
      pulse(0);
      step(80);
      pulse(2);
      step(1);
      chk("split_len", int'(length), 2);
      pulse(1);
      step(1);
      chk("split_w0", int'(data_out), 'h081);
      step(59);
      chk("split_d15_rdy", int'(output_ready), 1);
      step(1);
      chk("split_fetch", int'(output_ready), 0);
      step(1);
      chk("split_w1", int'(data_out), 'h081);
      step(19);
      chk("split_d5_rdy", int'(output_ready), 1);
      step(1);
      chk("split_end", int'(output_ready), 0);
      // alternating words fill all 8 entries and return to IDLE
      key = 10'h004;
      pulse(0);
      for (int i = 0; i < 9; i++) begin
         key = (i % 2 == 0) ? 10'h100 : 10'h004;
         step(4);
         if (i == 7) begin
            chk("fill_busy7", int'(rec_busy), 1);
            chk("fill_len7", int'(length), 0);
         end
      end
      chk("full_busy", int'(rec_busy), 0);
      chk("full_len", int'(length), 8);
      // async reset mid-HOLD
      pulse(1);
      step(3);
      chk("full_play_rdy", int'(output_ready), 1);
      chk("full_play_w0", int'(data_out), 'h100);
      rst = 1'b1;
      #1;
      chk("arst_rdy", int'(output_ready), 0);
      chk("arst_data", int'(data_out), 0);
      chk("arst_len", int'(length), 0);
      chk("arst_busy", int'(play_busy), 0);
      step(1);
      rst = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
